// File: rtl/sda_axil_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register bus bridge.
package sda_axil_reg_bridge_pkg;

  // Bridge FSM states; IDLE is encoded as zero so a reset state reads as 0.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RD_RESP = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit so the counter can always hold its terminal value.
  function automatic int timer_width(input int timeout_cycles, input int drain_cycles);
    return $clog2(max_int(timeout_cycles, drain_cycles)) + 1;
  endfunction

endpackage

// File: rtl/sda_axil_reg_bridge_if.sv
// AXI4-Lite slave-side bundle between the host control port and the bridge.
//
// Handshake: every channel transfers on a rising clk edge where valid and
// ready are both high. A source holds valid and its payload stable until
// that edge; a sink may raise ready in response to valid in the same cycle.
interface sda_axil_reg_bridge_if #(
  parameter int AxiAddrWidth = 12
);
  logic                    s_awvalid;
  logic                    s_awready;
  logic [AxiAddrWidth-1:0] s_awaddr;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [31:0]             s_wdata;
  logic [3:0]              s_wstrb;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [1:0]              s_bresp;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [AxiAddrWidth-1:0] s_araddr;
  logic                    s_rvalid;
  logic                    s_rready;
  logic [31:0]             s_rdata;
  logic [1:0]              s_rresp;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp
  );
endinterface

// File: rtl/sda_axil_reg_bridge_timer.sv
// Clear/enable up-counter with a terminal-count compare; shared by the
// request timeout and the post-abort drain window.
module sda_axil_reg_bridge_timer #(
  parameter int Width = 7
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] last,
  output logic             tc
);
  logic [Width-1:0] count_q, count_d;

  // Clear wins over count so a new phase always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == last);
endmodule

// File: rtl/sda_axil_reg_bridge.sv
// AXI4-Lite slave to single-outstanding register bus master with fair
// read/write arbitration, request timeout and a drain window for stray acks.
module sda_axil_reg_bridge
  import sda_axil_reg_bridge_pkg::*;
#(
  parameter int AxiAddrWidth  = 12,
  parameter int RegAddrWidth  = 8,
  parameter int TimeoutCycles = 64,
  parameter int DrainCycles   = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  sda_axil_reg_bridge_if.slave    s_axil,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  input  logic [31:0]             regRData,
  output state_e                  dbg_state
);
  localparam int TmrWidth = timer_width(TimeoutCycles, DrainCycles);
  localparam logic [TmrWidth-1:0] TimeoutLast = TmrWidth'(TimeoutCycles - 1);
  localparam logic [TmrWidth-1:0] DrainLast   = TmrWidth'(DrainCycles - 1);

  state_e                  state_q, state_d;
  logic                    prio_wr_q, prio_wr_d;
  logic                    we_q, we_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

  logic [AxiAddrWidth-1:0] aw_addr, ar_addr;
  logic                    wr_pend, rd_pend, contested, in_idle;
  logic                    grant_wr, grant_rd;
  logic                    req_active;
  logic                    tmr_clr, tmr_en, tmr_tc;
  logic [TmrWidth-1:0]     tmr_last;
  logic                    unused_addr_bits;

  assign aw_addr = s_axil.s_awaddr;
  assign ar_addr = s_axil.s_araddr;
  // Byte-lane bits and bits above the register window are not decoded.
  assign unused_addr_bits = ^{aw_addr, ar_addr};

  // A write needs both address and data before it can be granted. When both
  // types contend, prio_wr_q picks the winner and flips so the loser goes next.
  assign in_idle   = (state_q == ST_IDLE) && !srst;
  assign wr_pend   = s_axil.s_awvalid && s_axil.s_wvalid;
  assign rd_pend   = s_axil.s_arvalid;
  assign contested = wr_pend && rd_pend;
  assign grant_wr  = in_idle && wr_pend && (!rd_pend || prio_wr_q);
  assign grant_rd  = in_idle && rd_pend && (!wr_pend || !prio_wr_q);

  assign s_axil.s_awready = grant_wr;
  assign s_axil.s_wready  = grant_wr;
  assign s_axil.s_arready = grant_rd;

  // One timer: timeout while the request is up, drain length while draining.
  assign tmr_last = (state_q == ST_DRAIN) ? DrainLast : TimeoutLast;

  sda_axil_reg_bridge_timer #(.Width(TmrWidth)) u_timer (
    .clk  (clk),
    .srst (srst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last),
    .tc   (tmr_tc)
  );

  // Next-state, captured transaction and response computation.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          we_d    = 1'b1;
          addr_d  = aw_addr[RegAddrWidth+1:2];
          wdata_d = s_axil.s_wdata;
          tmr_clr = 1'b1;
          if (contested) prio_wr_d = 1'b0;
          // An all-zero strobe writes nothing, so the bus is never touched.
          if (s_axil.s_wstrb == 4'h0) begin
            resp_d  = RESP_OKAY;
            state_d = ST_WR_RESP;
          end else begin
            state_d = ST_WR_REQ;
          end
        end else if (grant_rd) begin
          we_d    = 1'b0;
          addr_d  = ar_addr[RegAddrWidth+1:2];
          wdata_d = '0;
          tmr_clr = 1'b1;
          if (contested) prio_wr_d = 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        tmr_en = 1'b1;
        // An ack in the limit cycle still completes the access.
        if (regAck) begin
          resp_d = RESP_OKAY;
          if (!we_q) rdata_d = regRData;
          state_d = we_q ? ST_WR_RESP : ST_RD_RESP;
        end else if (tmr_tc) begin
          resp_d  = RESP_SLVERR;
          if (!we_q) rdata_d = '0;
          tmr_clr = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = we_q ? ST_WR_RESP : ST_RD_RESP;
      end
      ST_WR_RESP: begin
        if (s_axil.s_bready) state_d = ST_IDLE;
      end
      ST_RD_RESP: begin
        if (s_axil.s_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-transaction registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Register bus is quiet (all zero) whenever no request is up.
  assign req_active = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign regReq     = req_active;
  assign regWriteEn = req_active && we_q;
  assign regAddr    = req_active ? addr_q : '0;
  assign regWData   = req_active ? wdata_q : '0;

  assign s_axil.s_bvalid = (state_q == ST_WR_RESP);
  assign s_axil.s_rvalid = (state_q == ST_RD_RESP);
  assign s_axil.s_bresp  = resp_q;
  assign s_axil.s_rresp  = resp_q;
  assign s_axil.s_rdata  = rdata_q;

  assign dbg_state = state_q;
endmodule

// File: tb/tb_sda_axil_reg_bridge.sv
// Directed bench for the AXI4-Lite register bridge with a kernel control
// register slave model (word address 0, acks two cycles after regReq rises).
module tb_sda_axil_reg_bridge;
  import sda_axil_reg_bridge_pkg::*;

  localparam int AW = 12;

  logic        clk  = 1'b0;
  logic        srst = 1'b1;
  logic        regReq, regAck, regWriteEn;
  logic [7:0]  regAddr;
  logic [31:0] regWData, regRData;
  state_e      dbg_state;

  logic        slave_en    = 1'b1;
  logic        slave_ack   = 1'b0;
  logic [31:0] slave_rdata = '0;
  logic [31:0] ctrl_reg    = '0;
  int          req_age     = 0;
  logic        inj_ack     = 1'b0;
  logic [31:0] inj_rdata   = '0;

  int checks   = 0;
  int failures = 0;
  int n, m;

  sda_axil_reg_bridge_if #(.AxiAddrWidth(AW)) axil ();

  sda_axil_reg_bridge #(
    .AxiAddrWidth(AW), .RegAddrWidth(8), .TimeoutCycles(64), .DrainCycles(4)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .s_axil     (axil),
    .regReq     (regReq),
    .regAck     (regAck),
    .regWriteEn (regWriteEn),
    .regAddr    (regAddr),
    .regWData   (regWData),
    .regRData   (regRData),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Wired-OR bus: slave model plus directed ack injection.
  assign regAck   = slave_ack | inj_ack;
  assign regRData = slave_rdata | inj_rdata;

  // Kernel control register slave: one ack two cycles after request rises.
  always @(posedge clk) begin
    if (srst || !regReq || !slave_en || regAddr != 8'h00) begin
      req_age     <= 0;
      slave_ack   <= 1'b0;
      slave_rdata <= '0;
    end else begin
      req_age     <= req_age + 1;
      slave_ack   <= (req_age == 1);
      slave_rdata <= (req_age == 1 && !regWriteEn) ? ctrl_reg : 32'h0;
      if (req_age == 1 && regWriteEn) ctrl_reg <= regWData;
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit wr, output int cnt);
    cnt = 0;
    while (((wr ? axil.s_bvalid : axil.s_rvalid) !== 1'b1) && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  task automatic take_resp(input bit wr);
    if (wr) axil.s_bready = 1'b1; else axil.s_rready = 1'b1;
    step();
    axil.s_bready = 1'b0;
    axil.s_rready = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step();
    step();
    srst = 1'b0;
    step();
  endtask

  task automatic drive_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    axil.s_awvalid = 1'b1;
    axil.s_awaddr  = addr;
    axil.s_wvalid  = 1'b1;
    axil.s_wdata   = data;
    axil.s_wstrb   = strb;
  endtask

  task automatic drop_write();
    axil.s_awvalid = 1'b0;
    axil.s_wvalid  = 1'b0;
  endtask

  initial begin
    axil.s_awvalid = 1'b0; axil.s_awaddr = '0; axil.s_wvalid = 1'b0;
    axil.s_wdata = '0; axil.s_wstrb = '0; axil.s_bready = 1'b0;
    axil.s_arvalid = 1'b0; axil.s_araddr = '0; axil.s_rready = 1'b0;

    // Reset state.
    do_reset();
    chk("rst_regReq", regReq, 0);
    chk("rst_regWriteEn", regWriteEn, 0);
    chk("rst_regAddr", regAddr, 0);
    chk("rst_regWData", regWData, 0);
    chk("rst_bvalid", axil.s_bvalid, 0);
    chk("rst_rvalid", axil.s_rvalid, 0);
    chk("rst_rdata", axil.s_rdata, 0);
    chk("rst_resp", {axil.s_bresp, axil.s_rresp}, 0);
    chk("rst_readies", {axil.s_awready, axil.s_wready, axil.s_arready}, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 1: write 0x1 to control register, bvalid at T+4.
    drive_write(12'h000, 32'h1, 4'hF);
    #1;
    chk("t1_awready", axil.s_awready, 1);
    chk("t1_wready", axil.s_wready, 1);
    chk("t1_arready", axil.s_arready, 0);
    step();
    drop_write();
    chk("t1_regReq", regReq, 1);
    chk("t1_regWriteEn", regWriteEn, 1);
    chk("t1_regAddr", regAddr, 0);
    chk("t1_regWData", regWData, 32'h1);
    wait_valid(1'b1, n);
    chk("t1_bvalid_lat", n, 3);
    chk("t1_bresp", axil.s_bresp, 2'b00);
    chk("t1_regReq_drop", regReq, 0);
    take_resp(1'b1);
    chk("t1_bvalid_clr", axil.s_bvalid, 0);
    chk("t1_ctrl_start", ctrl_reg, 32'h1);

    // 2: read control register back, rvalid at T+4; then rready stalled.
    axil.s_arvalid = 1'b1;
    axil.s_araddr  = 12'h000;
    #1;
    chk("t2_arready", axil.s_arready, 1);
    chk("t2_awready", axil.s_awready, 0);
    step();
    axil.s_arvalid = 1'b0;
    chk("t2_regReq", regReq, 1);
    chk("t2_regWriteEn", regWriteEn, 0);
    wait_valid(1'b0, n);
    chk("t2_rvalid_lat", n, 3);
    chk("t2_rdata_low", axil.s_rdata & 32'h7, 32'h1);
    chk("t2_rresp", axil.s_rresp, 2'b00);

    // 6a: rready low 10 cycles with another read waiting.
    axil.s_arvalid = 1'b1;
    axil.s_araddr  = 12'h000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t6_stall_arready", axil.s_arready, 0);
      chk("t6_stall_rvalid", axil.s_rvalid, 1);
      chk("t6_stall_rdata", axil.s_rdata, 32'h1);
      chk("t6_stall_rresp", axil.s_rresp, 2'b00);
      step();
    end
    axil.s_rready = 1'b1;
    #1;
    chk("t6_hs_arready", axil.s_arready, 0);
    step();
    axil.s_rready = 1'b0;
    #1;
    chk("t6_next_arready", axil.s_arready, 1);
    step();
    axil.s_arvalid = 1'b0;
    wait_valid(1'b0, n);
    chk("t6_next_lat", n, 3);
    chk("t6_next_rdata", axil.s_rdata, 32'h1);
    take_resp(1'b0);

    // 5: zero strobe write completes without a bus access.
    drive_write(12'h004, 32'hFFFF_FFFF, 4'h0);
    #1;
    chk("t5_awready", axil.s_awready, 1);
    step();
    drop_write();
    chk("t5_bvalid", axil.s_bvalid, 1);
    chk("t5_bresp", axil.s_bresp, 2'b00);
    chk("t5_regReq", regReq, 0);
    take_resp(1'b1);
    chk("t5_regReq_after", regReq, 0);

    // 4: read of unacked register 0x3FC times out, late ack ignored.
    axil.s_arvalid = 1'b1;
    axil.s_araddr  = 12'h3FC;
    #1;
    chk("t4_arready", axil.s_arready, 1);
    step();
    axil.s_arvalid = 1'b0;
    chk("t4_regAddr", regAddr, 8'hFF);
    n = 0;
    while (regReq === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("t4_req_cycles", n, 64);
    chk("t4_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    m = 0;
    inj_ack   = 1'b1;
    inj_rdata = 32'hDEAD_BEEF;
    step();
    m++;
    inj_ack   = 1'b0;
    inj_rdata = '0;
    while (axil.s_rvalid !== 1'b1 && m < 50) begin
      step();
      m++;
    end
    chk("t4_drain_cycles", m, 4);
    chk("t4_rresp", axil.s_rresp, 2'b10);
    chk("t4_rdata", axil.s_rdata, 32'h0);
    take_resp(1'b0);

    // 4b: ack exactly in the limit cycle wins.
    axil.s_arvalid = 1'b1;
    axil.s_araddr  = 12'h3FC;
    #1;
    chk("t4b_arready", axil.s_arready, 1);
    step();
    axil.s_arvalid = 1'b0;
    repeat (63) step();
    chk("t4b_regReq_last", regReq, 1);
    inj_ack   = 1'b1;
    inj_rdata = 32'h1234_5678;
    step();
    inj_ack   = 1'b0;
    inj_rdata = '0;
    chk("t4b_rvalid", axil.s_rvalid, 1);
    chk("t4b_rresp", axil.s_rresp, 2'b00);
    chk("t4b_rdata", axil.s_rdata, 32'h1234_5678);
    take_resp(1'b0);

    // 3: simultaneous write and read after reset: read first, then write.
    do_reset();
    drive_write(12'h000, 32'h5, 4'hF);
    axil.s_arvalid = 1'b1;
    axil.s_araddr  = 12'h000;
    #1;
    chk("t3a_arready", axil.s_arready, 1);
    chk("t3a_awready", axil.s_awready, 0);
    chk("t3a_wready", axil.s_wready, 0);
    step();
    axil.s_arvalid = 1'b0;
    chk("t3a_awready_busy", axil.s_awready, 0);
    wait_valid(1'b0, n);
    chk("t3a_rd_lat", n, 3);
    chk("t3a_rdata", axil.s_rdata, 32'h1);
    axil.s_rready = 1'b1;
    #1;
    chk("t3a_awready_hs", axil.s_awready, 0);
    step();
    axil.s_rready = 1'b0;
    #1;
    chk("t3a_wr_grant", {axil.s_awready, axil.s_wready}, 2'b11);
    step();
    drop_write();
    wait_valid(1'b1, n);
    chk("t3a_wr_lat", n, 3);
    take_resp(1'b1);
    chk("t3a_ctrl", ctrl_reg, 32'h5);

    // 3: second simultaneous pair: write first.
    drive_write(12'h000, 32'h7, 4'hF);
    axil.s_arvalid = 1'b1;
    axil.s_araddr  = 12'h000;
    #1;
    chk("t3b_awready", axil.s_awready, 1);
    chk("t3b_arready", axil.s_arready, 0);
    step();
    drop_write();
    wait_valid(1'b1, n);
    chk("t3b_wr_lat", n, 3);
    take_resp(1'b1);
    #1;
    chk("t3b_rd_grant", axil.s_arready, 1);
    step();
    axil.s_arvalid = 1'b0;
    wait_valid(1'b0, n);
    chk("t3b_rd_lat", n, 3);
    chk("t3b_rdata", axil.s_rdata, 32'h7);
    take_resp(1'b0);

    // 6b: srst during WR_REQ aborts silently.
    slave_en = 1'b0;
    drive_write(12'h000, 32'h9, 4'hF);
    #1;
    chk("t6b_awready", axil.s_awready, 1);
    step();
    drop_write();
    chk("t6b_regReq", regReq, 1);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("t6b_regReq", regReq, 0);
    chk("t6b_regWriteEn", regWriteEn, 0);
    chk("t6b_regAddr_wdata", {regAddr, regWData}, 0);
    chk("t6b_valids", {axil.s_bvalid, axil.s_rvalid}, 0);
    chk("t6b_state", 32'(dbg_state), 32'(ST_IDLE));
    m = 0;
    for (int i = 0; i < 10; i++) begin
      if (axil.s_bvalid === 1'b1 || regReq === 1'b1) m++;
      step();
    end
    chk("t6b_no_resp", m, 0);
    chk("t6b_ctrl_untouched", ctrl_reg, 32'h7);
    slave_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
